legv8_instr_encoder: RTL and testbench
======================================

LEGV8_INSTR_ENCODER -- requirements
Module: legv8_instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8: width of the instruction-memory write address.
REQ-002 Parameter BASE_ADDR, default 0: first write address after reset.
REQ-003 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_op  in  5  operation code, from the package enum.
REQ-009 req_rd, req_rn, req_rm  in  5 each  register fields.
REQ-010 req_imm  in  64  immediate or signed word offset.
REQ-011 req_cond  in  4  B.cond condition code.
REQ-012 wr_en  out  1  instruction word valid.
REQ-013 wr_ready  in  1  memory accepts the word.
REQ-014 wr_addr  out  ADDR_W  word address.
REQ-015 wr_data  out  32  encoded LEGv8 instruction.
REQ-016 err  out  1  one-cycle pulse: illegal op or immediate out of range.
REQ-017 wrapped  out  1  sticky flag: the address counter has wrapped.

Function
REQ-018 A request SHALL transfer on a cycle where req_valid and req_ready are both high; req_ready SHALL be high only in IDLE.
REQ-019 The FSM SHALL have three states: IDLE, EMIT and EXPAND. IDLE goes to EMIT on a legal transfer. EMIT goes to IDLE on a write transfer (wr_en and wr_ready high), or to EXPAND for LI64.
REQ-020 The first word SHALL appear on wr_data/wr_en in the cycle after the request transfers.
REQ-021 While wr_en is high and wr_ready is low, wr_en, wr_addr and wr_data SHALL hold stable.
REQ-022 Encodings SHALL use these formats. R: opcode[31:21], Rm, shamt=0, Rn, Rd. I: opcode[31:22], imm12. D: opcode[31:21], addr9[20:12], 00. B: opcode[31:26], imm26. CB: opcode[31:24], imm19[23:5]. IW: opcode[31:23], hw[22:21], imm16.
REQ-023 Supported ops SHALL be ADD, SUB, AND, ORR, EOR, ADDI, SUBI, ANDI, ORRI, LDUR, STUR, B, BL, CBZ, CBNZ, B.cond, BR, MOVZ, MOVK and LI64.
REQ-024 Range checks SHALL be: imm12 unsigned below 4096; addr9, imm19 and imm26 signed two's-complement in range; MOVZ/MOVK imm16 below 65536 with hw = req_rm[1:0].
REQ-025 An illegal op or out-of-range immediate SHALL be consumed, pulse err in the following cycle, emit no word, and leave the address unchanged.
REQ-026 wr_addr SHALL increment by one per write transfer and wrap from 2^ADDR_W-1 to 0; the wrap SHALL set wrapped.
REQ-027 B.cond SHALL place req_cond in [3:0] with bit 4 zero. BR SHALL place req_rn in [9:5] with Rm=11111 and the other fields zero.
REQ-028 LI64 SHALL emit four words on consecutive addresses: MOVZ with hw=0 and imm[15:0], then MOVK with hw=1, 2 and 3 carrying the successive 16-bit chunks; a 2-bit counter in EXPAND selects the chunk.

Reset
REQ-029 Reset SHALL force state to IDLE, wr_addr to BASE_ADDR, and wr_en, err and wrapped to 0. It SHALL abandon any pending word or LI64 sequence, and req_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-030 With LEGV8_LI64_EN defined, LI64 expansion SHALL be present. Without it, the EXPAND state SHALL be absent and LI64 SHALL be treated as illegal per REQ-025.

Structure
REQ-031 Shared package legv8_pkg SHALL hold the op enum, the opcode constants, the format field widths and the FSM state typedef.
REQ-032 Sub-module legv8_field_packer SHALL be purely combinational: op, fields and hw in; word and illegal flag out.

Verification
REQ-033 ADD with rd=3, rn=1, rm=2 -> wr_data=0x8B020023 at BASE_ADDR, one cycle after the transfer.
REQ-034 ADDI with rd=9, rn=10, imm=4 -> 0x91001149; ADDI with imm=4096 -> err pulse, no wr_en, address unchanged.
REQ-035 LI64 with rd=5, imm=0x1122334455667788 -> first word 0xD28EF105, last word 0xF2E22445, on four consecutive addresses; without the macro -> err only.
REQ-036 wr_ready held low 3 cycles during EMIT -> outputs stable and req_ready=0 until the transfer.
REQ-037 ADDR_W=2 with five legal requests -> addresses 0,1,2,3,0 and wrapped=1; reset asserted mid-LI64 -> IDLE, wr_addr=0, wr_en=0.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoder definitions: op enum, opcodes, field widths, FSM states.
// LEGV8_LI64_EN adds the EXPAND state used by the LI64 pseudo-op.
package legv8_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR,
        OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI,
        OP_LDUR, OP_STUR,
        OP_B, OP_BL, OP_CBZ, OP_CBNZ, OP_BCOND, OP_BR,
        OP_MOVZ, OP_MOVK, OP_LI64
    } op_e;

    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_AND  = 11'h450;
    localparam logic [10:0] OPC_ORR  = 11'h550;
    localparam logic [10:0] OPC_EOR  = 11'h650;
    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;
    localparam logic [10:0] OPC_BR   = 11'h6B0;
    localparam logic [9:0]  OPC_ADDI = 10'h244;
    localparam logic [9:0]  OPC_SUBI = 10'h344;
    localparam logic [9:0]  OPC_ANDI = 10'h248;
    localparam logic [9:0]  OPC_ORRI = 10'h2C8;
    localparam logic [5:0]  OPC_B    = 6'h05;
    localparam logic [5:0]  OPC_BL   = 6'h25;
    localparam logic [7:0]  OPC_CBZ  = 8'hB4;
    localparam logic [7:0]  OPC_CBNZ = 8'hB5;
    localparam logic [7:0]  OPC_BCND = 8'h54;
    localparam logic [8:0]  OPC_MOVZ = 9'h1A5;
    localparam logic [8:0]  OPC_MOVK = 9'h1E5;

    localparam int unsigned IMM12_W = 12;
    localparam int unsigned ADDR9_W = 9;
    localparam int unsigned IMM19_W = 19;
    localparam int unsigned IMM26_W = 26;
    localparam int unsigned IMM16_W = 16;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_EMIT   = 2'd1;
`ifdef LEGV8_LI64_EN
    localparam state_t ST_EXPAND = 2'd2;
`endif

    // True when value, read as a signed 64-bit number, fits a width-bit two's-complement field.
    function automatic logic fits_signed(input logic [63:0] value, input int unsigned width);
        logic signed [63:0] lim;
        lim = 64'sd1 <<< (width - 1);
        return ($signed(value) >= -lim) && ($signed(value) < lim);
    endfunction

endpackage

// File: rtl/legv8_field_packer.sv
// Combinational LEGv8 word packer with range checking.
// LI64 packs as its leading MOVZ only when LEGV8_LI64_EN is defined; otherwise it is illegal.
module legv8_field_packer
    import legv8_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rn_i,
    input  logic [4:0]  rm_i,
    input  logic [63:0] imm_i,
    input  logic [3:0]  cond_i,
    input  logic [1:0]  hw_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD:  word_o = {OPC_ADD, rm_i, 6'd0, rn_i, rd_i};
            OP_SUB:  word_o = {OPC_SUB, rm_i, 6'd0, rn_i, rd_i};
            OP_AND:  word_o = {OPC_AND, rm_i, 6'd0, rn_i, rd_i};
            OP_ORR:  word_o = {OPC_ORR, rm_i, 6'd0, rn_i, rd_i};
            OP_EOR:  word_o = {OPC_EOR, rm_i, 6'd0, rn_i, rd_i};
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: begin
                illegal_o = |imm_i[63:IMM12_W];
                case (op_i)
                    OP_ADDI: word_o = {OPC_ADDI, imm_i[IMM12_W-1:0], rn_i, rd_i};
                    OP_SUBI: word_o = {OPC_SUBI, imm_i[IMM12_W-1:0], rn_i, rd_i};
                    OP_ANDI: word_o = {OPC_ANDI, imm_i[IMM12_W-1:0], rn_i, rd_i};
                    default: word_o = {OPC_ORRI, imm_i[IMM12_W-1:0], rn_i, rd_i};
                endcase
            end
            OP_LDUR: begin
                illegal_o = !fits_signed(imm_i, ADDR9_W);
                word_o    = {OPC_LDUR, imm_i[ADDR9_W-1:0], 2'b00, rn_i, rd_i};
            end
            OP_STUR: begin
                illegal_o = !fits_signed(imm_i, ADDR9_W);
                word_o    = {OPC_STUR, imm_i[ADDR9_W-1:0], 2'b00, rn_i, rd_i};
            end
            OP_B, OP_BL: begin
                illegal_o = !fits_signed(imm_i, IMM26_W);
                word_o    = {(op_i == OP_BL) ? OPC_BL : OPC_B, imm_i[IMM26_W-1:0]};
            end
            OP_CBZ, OP_CBNZ: begin
                illegal_o = !fits_signed(imm_i, IMM19_W);
                word_o    = {(op_i == OP_CBNZ) ? OPC_CBNZ : OPC_CBZ, imm_i[IMM19_W-1:0], rd_i};
            end
            OP_BCOND: begin
                illegal_o = !fits_signed(imm_i, IMM19_W);
                word_o    = {OPC_BCND, imm_i[IMM19_W-1:0], 1'b0, cond_i};
            end
            OP_BR:   word_o = {OPC_BR, 5'b11111, 6'd0, rn_i, 5'd0};
            OP_MOVZ: begin
                illegal_o = |imm_i[63:IMM16_W];
                word_o    = {OPC_MOVZ, hw_i, imm_i[IMM16_W-1:0], rd_i};
            end
            OP_MOVK: begin
                illegal_o = |imm_i[63:IMM16_W];
                word_o    = {OPC_MOVK, hw_i, imm_i[IMM16_W-1:0], rd_i};
            end
`ifdef LEGV8_LI64_EN
            // Any 64-bit constant is legal; only its low chunk goes into this first word.
            OP_LI64: word_o = {OPC_MOVZ, 2'b00, imm_i[IMM16_W-1:0], rd_i};
`endif
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Request-driven LEGv8 instruction encoder that streams words into instruction memory.
// Define LEGV8_LI64_EN to enable the four-word LI64 expansion.
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rn,
    input  logic [4:0]        req_rm,
    input  logic [63:0]       req_imm,
    input  logic [3:0]        req_cond,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err,
    output logic              wrapped
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              err_q, wrapped_q;
    logic              req_xfer, wr_xfer, load_first, load_next;
    logic [4:0]        pk_op, pk_rd;
    logic [1:0]        pk_hw;
    logic [63:0]       pk_imm;
    logic [31:0]       pk_word;
    logic              pk_illegal;
`ifdef LEGV8_LI64_EN
    logic              li64_q;
    logic [1:0]        cnt_q, cnt_nxt;
    logic [47:0]       imm_hi_q;
    logic [4:0]        rd_q;
    logic [15:0]       chunk;
`endif

    assign req_ready = (state_q == ST_IDLE);
    assign wr_en     = (state_q != ST_IDLE);
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign err       = err_q;
    assign wrapped   = wrapped_q;
    assign req_xfer  = req_valid && req_ready;
    assign wr_xfer   = wr_en && wr_ready;

    // Outside IDLE the packer precomputes the next MOVK of an LI64 sequence.
    always_comb begin
        pk_op  = req_op;
        pk_rd  = req_rd;
        pk_hw  = req_rm[1:0];
        pk_imm = req_imm;
`ifdef LEGV8_LI64_EN
        cnt_nxt = cnt_q + 2'd1;
        case (cnt_nxt)
            2'd1:    chunk = imm_hi_q[15:0];
            2'd2:    chunk = imm_hi_q[31:16];
            default: chunk = imm_hi_q[47:32];
        endcase
        if (!req_ready) begin
            pk_op  = OP_MOVK;
            pk_rd  = rd_q;
            pk_hw  = cnt_nxt;
            pk_imm = {48'd0, chunk};
        end
`endif
    end

    legv8_field_packer u_packer (
        .op_i      (pk_op),
        .rd_i      (pk_rd),
        .rn_i      (req_rn),
        .rm_i      (req_rm),
        .imm_i     (pk_imm),
        .cond_i    (req_cond),
        .hw_i      (pk_hw),
        .word_o    (pk_word),
        .illegal_o (pk_illegal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_xfer && !pk_illegal) state_d = ST_EMIT;
            ST_EMIT: begin
                if (wr_xfer) begin
`ifdef LEGV8_LI64_EN
                    state_d = li64_q ? ST_EXPAND : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef LEGV8_LI64_EN
            ST_EXPAND: if (wr_xfer && (cnt_q == 2'd3)) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_first = req_xfer && !pk_illegal;
    assign load_next  = wr_xfer && (state_d != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= ADDR_W'(BASE_ADDR);
            wr_data_q <= '0;
            err_q     <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= req_xfer && pk_illegal;
            if (load_first || load_next) wr_data_q <= pk_word;
            if (wr_xfer) begin
                wr_addr_q <= wr_addr_q + ADDR_W'(1);
                if (&wr_addr_q) wrapped_q <= 1'b1;
            end
        end
    end

`ifdef LEGV8_LI64_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            li64_q   <= 1'b0;
            cnt_q    <= 2'd0;
            imm_hi_q <= '0;
            rd_q     <= '0;
        end else if (load_first) begin
            li64_q   <= (req_op == OP_LI64);
            cnt_q    <= 2'd0;
            imm_hi_q <= req_imm[63:16];
            rd_q     <= req_rd;
        end else if (load_next) begin
            cnt_q <= cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Self-checking bench for legv8_instr_encoder; expectations adapt to LEGV8_LI64_EN.
// Uses a narrow, offset address space so base and wrap behaviour both show up quickly.
module tb_legv8_instr_encoder;
    import legv8_pkg::*;

    localparam int ADDR_W    = 3;
    localparam int BASE_ADDR = 5;
    localparam int ADDR_MOD  = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_op, req_rd, req_rn, req_rm;
    logic [63:0]       req_imm;
    logic [3:0]        req_cond;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              err;
    logic              wrapped;

    int          compared    = 0;
    int          mismatched  = 0;
    int          expAddr     = BASE_ADDR;
    bit          expWrapped  = 1'b0;
    bit          expErr;
    logic [31:0] expWords[$];
    int          forcedStall = -1;

    legv8_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .req_rn    (req_rn),
        .req_rm    (req_rm),
        .req_imm   (req_imm),
        .req_cond  (req_cond),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err       (err),
        .wrapped   (wrapped)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction words built from field values by plain arithmetic on the ISA layouts.
    function automatic logic [31:0] rWord(input longint unsigned opc, input longint unsigned rm,
                                          input longint unsigned rn, input longint unsigned rd);
        return 32'(opc * 2**21 + rm * 2**16 + rn * 32 + rd);
    endfunction

    function automatic logic [31:0] iWord(input longint unsigned opc, input longint unsigned imm,
                                          input longint unsigned rn, input longint unsigned rd);
        return 32'(opc * 2**22 + (imm % 4096) * 1024 + rn * 32 + rd);
    endfunction

    function automatic logic [31:0] dWord(input longint unsigned opc, input longint unsigned imm,
                                          input longint unsigned rn, input longint unsigned rd);
        return 32'(opc * 2**21 + (imm % 512) * 4096 + rn * 32 + rd);
    endfunction

    function automatic logic [31:0] bWord(input longint unsigned opc, input longint unsigned imm);
        return 32'(opc * 2**26 + (imm % 2**26));
    endfunction

    function automatic logic [31:0] cbWord(input longint unsigned opc, input longint unsigned imm,
                                           input longint unsigned low);
        return 32'(opc * 2**24 + (imm % 2**19) * 32 + low);
    endfunction

    function automatic logic [31:0] iwWord(input longint unsigned opc, input longint unsigned hw,
                                           input longint unsigned imm, input longint unsigned rd);
        return 32'(opc * 2**23 + hw * 2**21 + (imm % 65536) * 32 + rd);
    endfunction

    function automatic bit fitsSigned(input longint v, input int bits);
        longint lim;
        lim = longint'(1) << (bits - 1);
        return (v >= -lim) && (v < lim);
    endfunction

    task automatic buildExpected(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rn,
                                 input logic [4:0] rm, input logic [63:0] imm, input logic [3:0] cond);
        longint unsigned u;
        longint          s;
        u = imm;
        s = longint'(imm);
        expErr = 1'b0;
        expWords.delete();
        case (op)
            OP_ADD:  expWords.push_back(rWord('h458, rm, rn, rd));
            OP_SUB:  expWords.push_back(rWord('h658, rm, rn, rd));
            OP_AND:  expWords.push_back(rWord('h450, rm, rn, rd));
            OP_ORR:  expWords.push_back(rWord('h550, rm, rn, rd));
            OP_EOR:  expWords.push_back(rWord('h650, rm, rn, rd));
            OP_ADDI: if (u >= 4096) expErr = 1; else expWords.push_back(iWord('h244, u, rn, rd));
            OP_SUBI: if (u >= 4096) expErr = 1; else expWords.push_back(iWord('h344, u, rn, rd));
            OP_ANDI: if (u >= 4096) expErr = 1; else expWords.push_back(iWord('h248, u, rn, rd));
            OP_ORRI: if (u >= 4096) expErr = 1; else expWords.push_back(iWord('h2C8, u, rn, rd));
            OP_LDUR: if (!fitsSigned(s, 9)) expErr = 1; else expWords.push_back(dWord('h7C2, u, rn, rd));
            OP_STUR: if (!fitsSigned(s, 9)) expErr = 1; else expWords.push_back(dWord('h7C0, u, rn, rd));
            OP_B:    if (!fitsSigned(s, 26)) expErr = 1; else expWords.push_back(bWord('h05, u));
            OP_BL:   if (!fitsSigned(s, 26)) expErr = 1; else expWords.push_back(bWord('h25, u));
            OP_CBZ:  if (!fitsSigned(s, 19)) expErr = 1; else expWords.push_back(cbWord('hB4, u, rd));
            OP_CBNZ: if (!fitsSigned(s, 19)) expErr = 1; else expWords.push_back(cbWord('hB5, u, rd));
            OP_BCOND: if (!fitsSigned(s, 19)) expErr = 1; else expWords.push_back(cbWord('h54, u, cond));
            OP_BR:   expWords.push_back(rWord('h6B0, 31, rn, 0));
            OP_MOVZ: if (u >= 65536) expErr = 1; else expWords.push_back(iwWord('h1A5, rm % 4, u, rd));
            OP_MOVK: if (u >= 65536) expErr = 1; else expWords.push_back(iwWord('h1E5, rm % 4, u, rd));
            OP_LI64: begin
`ifdef LEGV8_LI64_EN
                for (int k = 0; k < 4; k++)
                    expWords.push_back(iwWord((k == 0) ? 'h1A5 : 'h1E5, k, u >> (16 * k), rd));
`else
                expErr = 1;
`endif
            end
            default: expErr = 1;
        endcase
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rn,
                                 input logic [4:0] rm, input logic [63:0] imm, input logic [3:0] cond);
        int stall;
        buildExpected(op, rd, rn, rm, imm, cond);
        @(negedge clock);
        checkOutput("ready_idle", req_ready, 1);
        req_op = op; req_rd = rd; req_rn = rn; req_rm = rm; req_imm = imm; req_cond = cond;
        req_valid = 1'b1;
        wr_ready  = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        if (expErr) begin
            checkOutput("err_pulse", err, 1);
            checkOutput("err_no_wr", wr_en, 0);
            checkOutput("err_addr", wr_addr, expAddr);
            @(negedge clock);
            checkOutput("err_clear", err, 0);
            checkOutput("err_no_wr2", wr_en, 0);
        end else begin
            checkOutput("no_err", err, 0);
            foreach (expWords[i]) begin
                stall = (forcedStall >= 0) ? forcedStall : int'($urandom_range(0, 2));
                for (int s = 0; s <= stall; s++) begin
                    checkOutput("wr_en", wr_en, 1);
                    checkOutput("wr_data", wr_data, expWords[i]);
                    checkOutput("wr_addr", wr_addr, expAddr);
                    checkOutput("ready_busy", req_ready, 0);
                    wr_ready = (s == stall);
                    @(negedge clock);
                end
                wr_ready = 1'b0;
                expAddr  = (expAddr + 1) % ADDR_MOD;
                if (expAddr == 0) expWrapped = 1'b1;
            end
            checkOutput("idle_wr_en", wr_en, 0);
            checkOutput("idle_ready", req_ready, 1);
        end
        checkOutput("wrapped", wrapped, expWrapped);
        checkOutput("addr_idle", wr_addr, expAddr);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_wr_en"}, wr_en, 0);
        checkOutput({tag, "_addr"}, wr_addr, BASE_ADDR);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_wrapped"}, wrapped, 0);
        checkOutput({tag, "_ready"}, req_ready, 1);
    endtask

    initial begin
        longint      edges[16] = '{255, 256, -256, -257, 4095, 4096, 65535, 65536,
                                   262143, 262144, -262144, -262145,
                                   33554431, 33554432, -33554432, -33554433};
        logic [4:0]  op;
        logic [63:0] imm;

        reset = 1'b1; req_valid = 1'b0; wr_ready = 1'b0;
        req_op = '0; req_rd = '0; req_rn = '0; req_rm = '0; req_imm = '0; req_cond = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        checkResetState("reset");

        applyStimulus(OP_ADD, 5'd3, 5'd1, 5'd2, 64'd0, 4'd0);
        applyStimulus(OP_ADDI, 5'd9, 5'd10, 5'd0, 64'd4, 4'd0);
        applyStimulus(OP_ADDI, 5'd9, 5'd10, 5'd0, 64'd4096, 4'd0);
        applyStimulus(OP_LI64, 5'd5, 5'd0, 5'd0, 64'h1122334455667788, 4'd0);
        forcedStall = 3;
        applyStimulus(OP_SUB, 5'd7, 5'd8, 5'd9, 64'd0, 4'd0);
        forcedStall = -1;
        applyStimulus(OP_BR, 5'd4, 5'd30, 5'd6, 64'd0, 4'd0);
        applyStimulus(OP_BCOND, 5'd0, 5'd0, 5'd0, -64'd3, 4'hB);
        applyStimulus(OP_CBZ, 5'd12, 5'd0, 5'd0, -64'd262144, 4'd0);
        applyStimulus(OP_CBNZ, 5'd12, 5'd0, 5'd0, 64'd262144, 4'd0);
        applyStimulus(OP_LDUR, 5'd1, 5'd2, 5'd0, -64'd256, 4'd0);
        applyStimulus(OP_STUR, 5'd1, 5'd2, 5'd0, 64'd256, 4'd0);
        applyStimulus(OP_B, 5'd0, 5'd0, 5'd0, -64'd33554432, 4'd0);
        applyStimulus(OP_MOVK, 5'd6, 5'd0, 5'd3, 64'd65535, 4'd0);
        applyStimulus(OP_MOVZ, 5'd6, 5'd0, 5'd1, 64'd65536, 4'd0);
        applyStimulus(5'd25, 5'd6, 5'd0, 5'd1, 64'd1, 4'd0);

        for (int n = 0; n < 80; n++) begin
            op = 5'($urandom_range(0, 23));
            case ($urandom_range(0, 3))
                0:       imm = 64'($urandom_range(0, 5000));
                1:       imm = -64'($urandom_range(0, 300000));
                2:       imm = edges[$urandom_range(0, 15)];
                default: imm = {$urandom, $urandom};
            endcase
            applyStimulus(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), imm, 4'($urandom_range(0, 15)));
        end

        // Abandon an in-flight word (mid-LI64 when the expansion is built in).
        @(negedge clock);
`ifdef LEGV8_LI64_EN
        req_op = OP_LI64;
`else
        req_op = OP_ADD;
`endif
        req_rd = 5'd7; req_imm = 64'hDEADBEEF01234567; req_valid = 1'b1; wr_ready = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        checkOutput("mid_wr_en", wr_en, 1);
`ifdef LEGV8_LI64_EN
        wr_ready = 1'b1;
        @(negedge clock);
        wr_ready = 1'b0;
        checkOutput("mid_expand_wr_en", wr_en, 1);
`endif
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkResetState("mid_reset");
        expAddr    = BASE_ADDR;
        expWrapped = 1'b0;

        applyStimulus(OP_ORR, 5'd1, 5'd2, 5'd3, 64'd0, 4'd0);
        applyStimulus(OP_EOR, 5'd4, 5'd5, 5'd6, 64'd0, 4'd0);
        applyStimulus(OP_ORRI, 5'd31, 5'd31, 5'd0, 64'd4095, 4'd0);
        applyStimulus(OP_BL, 5'd0, 5'd0, 5'd0, 64'd33554431, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
